// File: rtl/fetch_sequencer.sv
// Program-fetch controller: walks the instruction ROM as a repeating scan and
// hands each fetched word to decode over a valid/ready handshake.
module fetch_sequencer #(
  parameter int INSTRUCTION_WIDTH = 40,
  parameter int PC_WIDTH          = 5,
  parameter int PROG_LEN          = 25,
  parameter int SCAN_CNT_WIDTH    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         halt,
  input  logic                         jump_en,
  input  logic [PC_WIDTH-1:0]          jump_addr,
  output logic [PC_WIDTH-1:0]          pc,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
  output logic [INSTRUCTION_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]          instr_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic                         running,
  output logic                         fault,
  output logic                         scan_done,
  output logic [SCAN_CNT_WIDTH-1:0]    scan_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(PROG_LEN - 1);

  // Handshake: a word transfers on any edge where instr_valid && instr_ready;
  // once valid is raised, instr_out/instr_pc hold until that transfer
  // (a jump or halt may withdraw the word).
  logic [1:0]          state;
  logic                slot;
  logic                jump_ok;
  logic [PC_WIDTH-1:0] next_pc;

  assign slot    = !instr_valid || instr_ready;
  assign jump_ok = jump_addr <= LAST_PC;
  assign next_pc = (pc == LAST_PC) ? '0 : pc + PC_WIDTH'(1);
  assign running = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      scan_done   <= 1'b0;
      scan_count  <= '0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !halt) state <= RUN;
        end
        RUN: begin
          if (halt) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
            // An unconsumed word is dropped, so rewind to re-fetch it on resume.
            if (instr_valid && !instr_ready) pc <= instr_pc;
          end else if (jump_en) begin
            instr_valid <= 1'b0;
            if (jump_ok) begin
              pc <= jump_addr;
            end else begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end else if (slot) begin
            instr_out   <= instr_in;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= next_pc;
            if (pc == LAST_PC) begin
              scan_done  <= 1'b1;
              scan_count <= scan_count + SCAN_CNT_WIDTH'(1);
            end
          end
        end
        FAULT: begin
          instr_valid <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: cycle model of the scan/handshake rules, a scoreboard
// of accepted instruction addresses, and directed scenarios with fixed expectations.
module tb_fetch_sequencer;

  localparam int IW = 40;
  localparam int PW = 5;
  localparam int PL = 25;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start = 1'b0;
  logic          halt = 1'b0;
  logic          jump_en = 1'b0;
  logic [PW-1:0] jump_addr = '0;
  logic [PW-1:0] pc;
  logic [IW-1:0] instr_in;
  logic [IW-1:0] instr_out;
  logic [PW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          running;
  logic          fault;
  logic          scan_done;
  logic [SW-1:0] scan_count;

  fetch_sequencer #(
    .INSTRUCTION_WIDTH(IW), .PC_WIDTH(PW), .PROG_LEN(PL), .SCAN_CNT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .jump_en(jump_en),
    .jump_addr(jump_addr), .pc(pc), .instr_in(instr_in), .instr_out(instr_out),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .running(running), .fault(fault), .scan_done(scan_done), .scan_count(scan_count)
  );

  // ROM holds its own address: ROM[i] = i
  assign instr_in = IW'(pc);

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: mode 0 idle, 1 run, 2 fault
  int m_mode = 0;
  int m_pc = 0;
  int m_ipc = 0;
  bit m_valid = 0;
  bit m_sd = 0;
  int m_scan = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_pc = 0; m_ipc = 0; m_valid = 0; m_sd = 0; m_scan = 0;
    end else begin
      m_sd = 0;
      if (m_mode == 0) begin
        if (start && !halt) m_mode = 1;
      end else if (m_mode == 1) begin
        if (halt) begin
          if (m_valid && !instr_ready) m_pc = m_ipc;
          m_valid = 0;
          m_mode = 0;
        end else if (jump_en) begin
          m_valid = 0;
          if (int'(jump_addr) < PL) m_pc = int'(jump_addr);
          else m_mode = 2;
        end else if (!m_valid || instr_ready) begin
          m_ipc = m_pc;
          m_valid = 1;
          if (m_pc == PL - 1) begin
            m_sd = 1;
            m_scan = (m_scan + 1) % (1 << SW);
          end
          m_pc = (m_pc + 1) % PL;
        end
      end
    end
  end

  // scoreboard of accepted instruction addresses
  logic [PW-1:0] exp_q[$];
  bit            sb_en = 0;
  int            hs_cnt = 0;

  bit            p_hold = 0;
  logic [PW-1:0] p_pc;
  logic [IW-1:0] p_out;

  // compare process
  always @(negedge clk) begin
    chk("pc", 64'(pc), 64'(m_pc));
    chk("instr_valid", 64'(instr_valid), 64'(m_valid));
    chk("running", 64'(running), 64'(m_mode == 1));
    chk("fault", 64'(fault), 64'(m_mode == 2));
    chk("scan_done", 64'(scan_done), 64'(m_sd));
    chk("scan_count", 64'(scan_count), 64'(m_scan));
    if (m_valid) begin
      chk("instr_pc", 64'(instr_pc), 64'(m_ipc));
      chk("instr_out", 64'(instr_out), 64'(m_ipc));
    end
    if (p_hold) begin
      chk("hold_valid", 64'(instr_valid), 64'd1);
      chk("hold_pc", 64'(instr_pc), 64'(p_pc));
      chk("hold_out", 64'(instr_out), 64'(p_out));
    end
    if (scan_done) chk("scan_done_pc", 64'(instr_pc), 64'(PL - 1));
    if (sb_en && instr_valid && instr_ready) begin
      hs_cnt++;
      if (exp_q.size() > 0) chk("sb_pc", 64'(instr_pc), 64'(exp_q.pop_front()));
    end
    p_hold = instr_valid && !instr_ready && !halt && !jump_en && !rst;
    p_pc   = instr_pc;
    p_out  = instr_out;
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input int first, input int count);
    for (int i = 0; i < count; i++) exp_q.push_back(PW'((first + i) % PL));
  endtask

  initial begin
    rst = 1'b1;
    step(2);
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_scan_count", 64'(scan_count), 64'd0);
    rst = 1'b0;
    step(1);

    // sequential scan, ready held high
    push_seq(0, 27);
    hs_cnt = 0; sb_en = 1;
    start = 1; instr_ready = 1;
    step(1);
    chk("start_running", 64'(running), 64'd1);
    chk("start_valid", 64'(instr_valid), 64'd0);
    start = 0;
    step(1);
    chk("first_valid", 64'(instr_valid), 64'd1);
    chk("first_pc", 64'(instr_pc), 64'd0);
    step(26);
    @(negedge clk); #1;
    sb_en = 0;
    chk("seq_hs", 64'(hs_cnt), 64'd27);
    chk("seq_left", 64'(exp_q.size()), 64'd0);
    chk("seq_scans", 64'(scan_count), 64'd1);
    halt = 1;
    step(1);
    halt = 0;
    chk("halt1_running", 64'(running), 64'd0);
    chk("halt1_pc", 64'(pc), 64'd2);

    // ready toggling: 25 words in 49 cycles, resuming at address 2
    push_seq(2, 25);
    hs_cnt = 0; sb_en = 1;
    start = 1; instr_ready = 0;
    step(1);
    start = 0;
    step(1);
    for (int i = 0; i < 49; i++) begin
      instr_ready = (i % 2 == 0);
      step(1);
    end
    instr_ready = 0;
    sb_en = 0;
    chk("tog_hs", 64'(hs_cnt), 64'd25);
    chk("tog_left", 64'(exp_q.size()), 64'd0);
    chk("tog_scans", 64'(scan_count), 64'd2);

    // jump flushes the word being accepted
    instr_ready = 1;
    step(5);
    chk("pre_jump_pc", 64'(instr_pc), 64'd7);
    jump_en = 1; jump_addr = 5'd3;
    step(1);
    jump_en = 0;
    chk("jump_valid", 64'(instr_valid), 64'd0);
    chk("jump_pc", 64'(pc), 64'd3);
    step(1);
    chk("jump_tgt_valid", 64'(instr_valid), 64'd1);
    chk("jump_tgt_pc", 64'(instr_pc), 64'd3);
    chk("jump_tgt_out", 64'(instr_out), 64'd3);

    // illegal jump target
    jump_en = 1; jump_addr = 5'd30;
    step(1);
    chk("flt_fault", 64'(fault), 64'd1);
    chk("flt_running", 64'(running), 64'd0);
    chk("flt_valid", 64'(instr_valid), 64'd0);
    chk("flt_pc", 64'(pc), 64'd4);
    start = 1; jump_addr = 5'd5;
    step(3);
    start = 0; jump_en = 0;
    chk("flt_sticky", 64'(fault), 64'd1);
    chk("flt_pc_hold", 64'(pc), 64'd4);
    rst = 1;
    #1;
    chk("flt_rst_fault", 64'(fault), 64'd0);
    chk("flt_rst_pc", 64'(pc), 64'd0);
    step(1);
    rst = 0;
    step(1);

    // halt with an unconsumed word
    instr_ready = 1; start = 1;
    step(1);
    start = 0;
    step(11);
    chk("pre_halt_pc", 64'(instr_pc), 64'd10);
    instr_ready = 0; halt = 1;
    step(1);
    halt = 0;
    chk("halt2_running", 64'(running), 64'd0);
    chk("halt2_valid", 64'(instr_valid), 64'd0);
    chk("halt2_pc", 64'(pc), 64'd10);
    instr_ready = 1; start = 1;
    step(1);
    start = 0;
    step(1);
    chk("resume_valid", 64'(instr_valid), 64'd1);
    chk("resume_pc", 64'(instr_pc), 64'd10);

    // asynchronous reset mid-stream
    step(5);
    chk("pre_rst_pc", 64'(instr_pc), 64'd15);
    #1 rst = 1;
    #1;
    chk("arst_pc", 64'(pc), 64'd0);
    chk("arst_instr_pc", 64'(instr_pc), 64'd0);
    chk("arst_instr_out", 64'(instr_out), 64'd0);
    chk("arst_valid", 64'(instr_valid), 64'd0);
    chk("arst_running", 64'(running), 64'd0);
    chk("arst_scan_count", 64'(scan_count), 64'd0);
    step(1);
    rst = 0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
